load_store_unit: RTL and testbench

Sits between the CPU memory stage and the 256×32 word data memory. Accepts byte/halfword/word loads and stores at byte addresses and converts them to word-wide memory accesses. Sub-word stores use read-modify-write; loads return sign- or zero-extended results. Misaligned requests are flagged without touching memory.

---
 rtl/load_store_unit_if.sv | 45 ++++
 rtl/load_store_unit.sv | 183 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if
//   Bundles the CPU-side request/response handshake and the data-memory
//   port of the load/store unit.
//   Request  : req_valid, req_ready, req_we, req_size, req_unsigned,
//              req_addr, req_wdata
//   Response : resp_valid, resp_rdata, resp_err
//   Memory   : mem_read, mem_write, mem_address, mem_write_data,
//              mem_read_data (combinational, 0 when mem_read is low)
//   Modports : slave  = the load/store unit itself
//              master = its environment (CPU stage plus data memory)
`timescale 1ns/1ps

interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_read, mem_write, mem_address, mem_write_data
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_read, mem_write, mem_address, mem_write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
//   Converts byte/halfword/word loads and stores at byte addresses into
//   word-wide accesses to a 256x32 data memory. Sub-word stores are done as
//   read-modify-write; loads are sign- or zero-extended; misaligned or
//   illegal-size requests complete with resp_err and never touch memory.
//   Ports:
//     clk   - system clock, rising edge
//     rst_n - asynchronous active-low reset
//     bus   - load_store_unit_if.slave (request, response, memory port)
`timescale 1ns/1ps

module load_store_unit (
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t      state_reg, state_next;
    logic [9:0]  addr_reg, addr_next;
    logic [1:0]  size_reg, size_next;
    logic        we_reg, we_next;
    logic        uns_reg, uns_next;
    logic [31:0] wdata_reg, wdata_next;
    logic        err_reg, err_next;
    logic [31:0] old_word_reg, old_word_next;
    logic [7:0]  mem_address_reg, mem_address_next;
    logic [31:0] mem_write_data_reg, mem_write_data_next;

    // Address bits above the 1 KiB window are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, bus.req_addr[31:10]};

    // Alignment / size check on the live request (only used at acceptance).
    logic req_err;
    always_comb begin
        req_err = 1'b0;
        case (bus.req_size)
            SIZE_BYTE: req_err = 1'b0;
            SIZE_HALF: req_err = bus.req_addr[0];
            SIZE_WORD: req_err = (bus.req_addr[1:0] != 2'b00);
            default:   req_err = 1'b1;
        endcase
    end

    // Byte-lane enables and lane-replicated store data for the merge.
    logic [3:0]  lane_en;
    logic [31:0] lane_data;
    always_comb begin
        lane_en   = 4'b1111;
        lane_data = wdata_reg;
        case (size_reg)
            SIZE_BYTE: begin
                lane_en   = 4'b0001 << addr_reg[1:0];
                lane_data = {4{wdata_reg[7:0]}};
            end
            SIZE_HALF: begin
                lane_en   = addr_reg[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wdata_reg[15:0]}};
            end
            default: begin
                lane_en   = 4'b1111;
                lane_data = wdata_reg;
            end
        endcase
    end

    // Old word from memory with the selected lanes replaced.
    logic [31:0] merged_word;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merged_word[8*gi +: 8] = lane_en[gi] ? lane_data[8*gi +: 8]
                                                        : bus.mem_read_data[8*gi +: 8];
        end
    endgenerate

    // Load result: pick the lane from the captured word, shift to bit 0, extend.
    logic [31:0] byte_shift;
    logic [15:0] half_sel;
    logic [31:0] load_result;
    assign byte_shift = old_word_reg >> {addr_reg[1:0], 3'b000};
    assign half_sel   = addr_reg[1] ? old_word_reg[31:16] : old_word_reg[15:0];
    always_comb begin
        load_result = old_word_reg;
        case (size_reg)
            SIZE_BYTE: load_result = {{24{~uns_reg & byte_shift[7]}}, byte_shift[7:0]};
            SIZE_HALF: load_result = {{16{~uns_reg & half_sel[15]}}, half_sel};
            default:   load_result = old_word_reg;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= IDLE;
            addr_reg           <= '0;
            size_reg           <= '0;
            we_reg             <= 1'b0;
            uns_reg            <= 1'b0;
            wdata_reg          <= '0;
            err_reg            <= 1'b0;
            old_word_reg       <= '0;
            mem_address_reg    <= '0;
            mem_write_data_reg <= '0;
        end else begin
            state_reg          <= state_next;
            addr_reg           <= addr_next;
            size_reg           <= size_next;
            we_reg             <= we_next;
            uns_reg            <= uns_next;
            wdata_reg          <= wdata_next;
            err_reg            <= err_next;
            old_word_reg       <= old_word_next;
            mem_address_reg    <= mem_address_next;
            mem_write_data_reg <= mem_write_data_next;
        end
    end

    // Next-state and datapath-update logic.
    always_comb begin
        state_next          = state_reg;
        addr_next           = addr_reg;
        size_next           = size_reg;
        we_next             = we_reg;
        uns_next            = uns_reg;
        wdata_next          = wdata_reg;
        err_next            = err_reg;
        old_word_next       = old_word_reg;
        mem_address_next    = mem_address_reg;
        mem_write_data_next = mem_write_data_reg;

        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_next        = bus.req_addr[9:0];
                    size_next        = bus.req_size;
                    we_next          = bus.req_we;
                    uns_next         = bus.req_unsigned;
                    wdata_next       = bus.req_wdata;
                    err_next         = req_err;
                    mem_address_next = bus.req_addr[9:2];
                    if (req_err) begin
                        state_next = RESP;
                    end else if (bus.req_we && bus.req_size == SIZE_WORD) begin
                        // Full-word store needs no old data.
                        mem_write_data_next = bus.req_wdata;
                        state_next          = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD: begin
                old_word_next = bus.mem_read_data;
                if (we_reg) begin
                    mem_write_data_next = merged_word;
                    state_next          = WR;
                end else begin
                    state_next = RESP;
                end
            end
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state so reset drops them immediately.
    assign bus.req_ready      = rst_n && (state_reg == IDLE);
    assign bus.resp_valid     = (state_reg == RESP);
    assign bus.resp_err       = (state_reg == RESP) && err_reg;
    assign bus.resp_rdata     = (state_reg == RESP && !err_reg && !we_reg) ? load_result : '0;
    assign bus.mem_read       = (state_reg == RD);
    assign bus.mem_write      = (state_reg == WR);
    assign bus.mem_address    = {24'b0, mem_address_reg};
    assign bus.mem_write_data = mem_write_data_reg;

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps

module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if bus();

    load_store_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Data memory attached to the unit.
    logic [31:0] mem [256] = '{default: 32'h0};
    assign bus.mem_read_data = bus.mem_read ? mem[bus.mem_address[7:0]] : 32'h0;
    always @(posedge clk) if (bus.mem_write) mem[bus.mem_address[7:0]] <= bus.mem_write_data;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: a flat 1 KiB byte array.
    logic [7:0] ref_bytes [1024] = '{default: 8'h0};

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nrd;
        int          nwr;
        int          widx;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(logic we, logic [1:0] size, logic uns,
                                   logic [31:0] addr, logic [31:0] wdata);
        exp_t e;
        int nbytes;
        int base;
        longint v;
        base   = int'(addr % 1024);
        e.err  = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
                 (size == 2'd2 && addr % 4 != 0);
        e.rdata = 32'h0;
        e.widx  = base / 4;
        e.acc   = 0;
        if (e.err) begin
            e.lat = 1; e.nrd = 0; e.nwr = 0;
            return e;
        end
        nbytes = 1 << size;
        if (we) begin
            for (int i = 0; i < nbytes; i++)
                ref_bytes[base + i] = 8'(wdata >> (8 * i));
            e.lat = (nbytes == 4) ? 2 : 3;
            e.nrd = (nbytes == 4) ? 0 : 1;
            e.nwr = 1;
        end else begin
            v = 0;
            for (int i = 0; i < nbytes; i++)
                v += longint'(ref_bytes[base + i]) << (8 * i);
            if (!uns && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1)))
                v -= (longint'(1) << (8 * nbytes));
            e.rdata = 32'(v);
            e.lat = 2; e.nrd = 1; e.nwr = 0;
        end
        return e;
    endfunction

    task automatic scramble_inputs();
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
        bus.req_size     = 2'($urandom_range(0, 3));
        bus.req_we       = 1'($urandom_range(0, 1));
        bus.req_unsigned = 1'($urandom_range(0, 1));
    endtask

    task automatic issue(logic we, logic [1:0] size, logic uns,
                         logic [31:0] addr, logic [31:0] wdata);
        exp_t e;
        int waited;
        waited = 0;
        @(negedge clk);
        while (!bus.req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) begin
            total++; bad++;
            $display("FAIL ready_timeout: req_ready still %b after %0d cycles, required 1", bus.req_ready, waited);
            return;
        end
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        e = model(we, size, uns, addr, wdata);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        scramble_inputs();   // latched values must not follow later input changes
    endtask

    // Monitor: counts memory strobes and checks each response against the queue.
    int rd_cnt = 0;
    int wr_cnt = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rd_cnt = 0;
                wr_cnt = 0;
            end else begin
                if (bus.mem_read)  rd_cnt++;
                if (bus.mem_write) wr_cnt++;
                if (bus.resp_valid) begin
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_resp: resp_valid=1 rdata=%h err=%b, required no response",
                                 bus.resp_rdata, bus.resp_err);
                    end else begin
                        e = sb.pop_front();
                        $display("resp: err=%b rdata=%h lat=%0d rd=%0d wr=%0d",
                                 bus.resp_err, bus.resp_rdata, cyc - e.acc + 1, rd_cnt, wr_cnt);
                        check("resp_err",   32'(bus.resp_err), 32'(e.err));
                        check("resp_rdata", bus.resp_rdata, e.rdata);
                        check("latency",    32'(cyc - e.acc + 1), 32'(e.lat));
                        check("mem_reads",  32'(rd_cnt), 32'(e.nrd));
                        check("mem_writes", 32'(wr_cnt), 32'(e.nwr));
                        if (!e.err) check("mem_address", bus.mem_address, 32'(e.widx));
                    end
                    rd_cnt = 0;
                    wr_cnt = 0;
                end
            end
        end
    end

    task automatic check_all_zero(string tag);
        check({tag, "_resp_valid"},     32'(bus.resp_valid), 32'h0);
        check({tag, "_resp_err"},       32'(bus.resp_err), 32'h0);
        check({tag, "_resp_rdata"},     bus.resp_rdata, 32'h0);
        check({tag, "_mem_read"},       32'(bus.mem_read), 32'h0);
        check({tag, "_mem_write"},      32'(bus.mem_write), 32'h0);
        check({tag, "_mem_address"},    bus.mem_address, 32'h0);
        check({tag, "_mem_write_data"}, bus.mem_write_data, 32'h0);
        check({tag, "_req_ready"},      32'(bus.req_ready), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, sb depth %0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [31:0] a;
        logic [1:0]  sz;
        int r;

        bus.req_valid = 1'b0;
        scramble_inputs();

        // Power-on reset.
        #1 rst_n = 1'b0;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", 32'(bus.req_ready), 32'h1);

        // Directed cases.
        issue(1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h10,  32'h0);
        issue(1'b1, 2'd2, 1'b0, 32'h10,  32'h11223344);
        issue(1'b1, 2'd0, 1'b0, 32'h11,  32'h000000AA);
        issue(1'b0, 2'd2, 1'b0, 32'h10,  32'h0);
        issue(1'b0, 2'd0, 1'b0, 32'h11,  32'h0);
        issue(1'b0, 2'd0, 1'b1, 32'h11,  32'h0);
        issue(1'b1, 2'd1, 1'b0, 32'h22,  32'h00008001);
        issue(1'b0, 2'd1, 1'b0, 32'h22,  32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h20,  32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h13,  32'h0);
        issue(1'b1, 2'd1, 1'b0, 32'h05,  32'h00001234);
        issue(1'b0, 2'd3, 1'b0, 32'h40,  32'h0);
        issue(1'b1, 2'd3, 1'b0, 32'h40,  32'hFFFFFFFF);
        issue(1'b1, 2'd2, 1'b0, 32'h404, 32'h00000055);
        issue(1'b0, 2'd2, 1'b0, 32'h004, 32'h0);

        // Reset during the read phase of a byte store: nothing may be written.
        @(negedge clk);
        w = 0;
        while (!bus.req_ready && w < 50) begin @(negedge clk); w++; end
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h31; bus.req_wdata = 32'h77;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("abort_in_rd", 32'(bus.mem_read), 32'h1);
        rst_n = 1'b0;
        #1;
        $display("abort: rst_n low during RD of byte store");
        check_all_zero("abort");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_abort", 32'(bus.req_ready), 32'h1);

        // Randomized traffic within a 64-byte window, upper bits random.
        for (int n = 0; n < 300; n++) begin
            r  = int'($urandom_range(0, 9));
            sz = (r == 9) ? 2'd3 : 2'(r % 3);
            a  = $urandom;
            a[9:6] = 4'h0;
            if (sz != 2'd3 && $urandom_range(0, 3) != 0)
                a = a & ~((32'h1 << sz) - 32'h1);
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end

        // Drain outstanding responses.
        w = 0;
        while (sb.size() != 0 && w < 100) begin @(negedge clk); w++; end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: %0d responses missing, required 0", sb.size());
        end
        repeat (3) @(negedge clk);

        // Memory contents must match the byte-level model.
        for (int i = 0; i < 256; i++)
            check($sformatf("mem_word_%0d", i), mem[i],
                  {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
